// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } tt_state_e;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 2;

    // Number of distinct input vectors for an n-input block.
    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bus between the sweep checker and its environment (block under test
// plus whoever issues start and reads the results).
interface truth_table_checker_if #(
    parameter int N_IN = 4
);
    import tt_check_pkg::*;

    logic                       start;
    logic [N_IN-1:0]            stim;
    logic                       resp;
    logic                       busy;
    logic                       done;
    logic                       pass;
    logic [vec_count(N_IN)-1:0] captured;
    logic [N_IN:0]              fail_count;
    logic [N_IN-1:0]            first_fail_idx;

    // Environment side: requests sweeps and returns the block's response.
    modport master (
        output start,
        output resp,
        input  stim,
        input  busy,
        input  done,
        input  pass,
        input  captured,
        input  fail_count,
        input  first_fail_idx
    );

    // Checker side.
    modport slave (
        input  start,
        input  resp,
        output stim,
        output busy,
        output done,
        output pass,
        output captured,
        output fail_count,
        output first_fail_idx
    );

endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps every input vector, holds each one
// for SETTLE+1 cycles, samples the 1-bit response and compares it against a
// golden table.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// APPLY  | stim = idx held, settle down-counter running
// SAMPLE | response for idx captured and compared at the closing edge
// DONE   | sweep complete, results held until next start
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                         N_IN     = DEF_N_IN,
    parameter logic [vec_count(N_IN)-1:0] EXPECTED = '0,
    parameter int                         SETTLE   = DEF_SETTLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  bus
);

    localparam int                VEC         = vec_count(N_IN);
    localparam logic [N_IN-1:0]   LAST_IDX    = N_IN'(VEC - 1);
    localparam logic [N_IN:0]     FAIL_MAX    = (N_IN + 1)'(VEC);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);

    tt_state_e          state_q;
    logic [N_IN-1:0]    idx_q;
    logic [N_IN-1:0]    stim_q;
    logic [3:0]         settle_q;
    logic               seen_fail_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [VEC-1:0]     captured_q;
    logic [N_IN:0]      fail_count_q;
    logic [N_IN:0]      fail_count_d;
    logic [N_IN-1:0]    first_fail_q;
    logic               mismatch;

    assign mismatch = (bus.resp != EXPECTED[idx_q]);

    // Mismatch count including the vector being sampled now; saturates.
    always_comb begin
        fail_count_d = fail_count_q;
        if (mismatch && (fail_count_q != FAIL_MAX)) begin
            fail_count_d = fail_count_q + 1'b1;
        end
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            stim_q       <= '0;
            settle_q     <= '0;
            seen_fail_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            captured_q   <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q      <= APPLY;
                        idx_q        <= '0;
                        stim_q       <= '0;
                        settle_q     <= SETTLE_LOAD;
                        seen_fail_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        captured_q   <= '0;
                        fail_count_q <= '0;
                        first_fail_q <= '0;
                    end
                end
                APPLY: begin
                    if (settle_q == 4'd0) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    captured_q[idx_q] <= bus.resp;
                    fail_count_q      <= fail_count_d;
                    if (mismatch && !seen_fail_q) begin
                        first_fail_q <= idx_q;
                        seen_fail_q  <= 1'b1;
                    end
                    // Terminal compare comes first, so idx never wraps.
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count_d == '0);
                    end else begin
                        state_q  <= APPLY;
                        idx_q    <= idx_q + 1'b1;
                        stim_q   <= idx_q + 1'b1;
                        settle_q <= SETTLE_LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stim           = stim_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.captured       = captured_q;
    assign bus.fail_count     = fail_count_q;
    assign bus.first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=2 and SETTLE=1)
// around the gate network y = (a&b)|(c&d), with a timeline model of the
// sweep checked every cycle plus literal expectations per scenario.
module tb_truth_table_checker;

    localparam logic [15:0] EXP_TT = 16'hF888;

    typedef struct {
        logic [3:0]  stim;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] cap;
        logic [4:0]  fc;
        logic [3:0]  ff;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start;
    int   mode;

    int checks = 0;
    int errors = 0;

    int run_a, k_a, mode_a;
    int run_b, k_b, mode_b;
    exp_t ea, eb;

    truth_table_checker_if #(.N_IN(4)) if_a ();
    truth_table_checker_if #(.N_IN(4)) if_b ();

    truth_table_checker #(.N_IN(4), .EXPECTED(EXP_TT), .SETTLE(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    truth_table_checker #(.N_IN(4), .EXPECTED(EXP_TT), .SETTLE(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block under test: mode 0 good, 1 = output inverted at vector 5, 2 = stuck at 0.
    function automatic logic fn(input int j, input int m);
        logic a, b, c, d, y;
        a = j[3];
        b = j[2];
        c = j[1];
        d = j[0];
        y = (a & b) | (c & d);
        if (m == 1 && j == 5) y = ~y;
        if (m == 2) y = 1'b0;
        return y;
    endfunction

    assign if_a.start = start;
    assign if_b.start = start;
    assign if_a.resp  = fn(int'(if_a.stim), mode);
    assign if_b.resp  = fn(int'(if_b.stim), mode);

    // Expected outputs k edges after an accepted start, from sweep arithmetic.
    function automatic exp_t model(input int k, input int run, input int s, input int m);
        exp_t e;
        int n, fails, first;
        e.stim = '0; e.busy = 0; e.done = 0; e.pass = 0;
        e.cap = '0; e.fc = '0; e.ff = '0;
        if (run == 0) return e;
        n = k / (s + 1);
        if (n > 16) n = 16;
        fails = 0;
        first = -1;
        for (int j = 0; j < n; j++) begin
            logic r;
            r = fn(j, m);
            e.cap[j] = r;
            if (r != EXP_TT[j]) begin
                fails++;
                if (first < 0) first = j;
            end
        end
        e.stim = (n == 16) ? 4'd15 : 4'(n);
        e.busy = (n < 16);
        e.done = (n == 16);
        e.pass = (n == 16) && (fails == 0);
        e.fc   = 5'(fails);
        e.ff   = (first < 0) ? 4'd0 : 4'(first);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model timeline: edges since the last accepted start.
    always @(posedge clk) begin
        if (!rst_n) begin
            run_a <= 0; k_a <= 0;
            run_b <= 0; k_b <= 0;
        end else begin
            if (start && !(run_a != 0 && k_a / 3 < 16)) begin
                run_a <= 1; k_a <= 0; mode_a <= mode;
            end else if (run_a != 0 && k_a < 48) begin
                k_a <= k_a + 1;
            end
            if (start && !(run_b != 0 && k_b / 2 < 16)) begin
                run_b <= 1; k_b <= 0; mode_b <= mode;
            end else if (run_b != 0 && k_b < 32) begin
                k_b <= k_b + 1;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if ($time > 0) begin
            ea = model(k_a, run_a, 2, mode_a);
            eb = model(k_b, run_b, 1, mode_b);
            chk("a_stim", 32'(if_a.stim), 32'(ea.stim));
            chk("a_busy", 32'(if_a.busy), 32'(ea.busy));
            chk("a_done", 32'(if_a.done), 32'(ea.done));
            chk("a_pass", 32'(if_a.pass), 32'(ea.pass));
            chk("a_captured", 32'(if_a.captured), 32'(ea.cap));
            chk("a_fail_count", 32'(if_a.fail_count), 32'(ea.fc));
            chk("a_first_fail", 32'(if_a.first_fail_idx), 32'(ea.ff));
            chk("b_stim", 32'(if_b.stim), 32'(eb.stim));
            chk("b_busy", 32'(if_b.busy), 32'(eb.busy));
            chk("b_done", 32'(if_b.done), 32'(eb.done));
            chk("b_pass", 32'(if_b.pass), 32'(eb.pass));
            chk("b_captured", 32'(if_b.captured), 32'(eb.cap));
            chk("b_fail_count", 32'(if_b.fail_count), 32'(eb.fc));
            chk("b_first_fail", 32'(if_b.first_fail_idx), 32'(eb.ff));
        end
    end

    // Pulse start, optionally re-pulse at cycle pulse_at, return cycles to done.
    task automatic run_sweep(input int pulse_at, output int ca, output int cb);
        int c;
        ca = -1;
        cb = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_clears_done", 32'(if_a.done), 32'd0);
        chk("start_sets_busy", 32'(if_a.busy), 32'd1);
        chk("start_clears_captured", 32'(if_a.captured), 32'd0);
        chk("start_clears_fail_count", 32'(if_a.fail_count), 32'd0);
        c = 0;
        while (ca < 0 && c < 200) begin
            start = (c == pulse_at);
            @(negedge clk);
            c++;
            if (if_b.done && cb < 0) cb = c;
            if (if_a.done) ca = c;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] cap,
                                input int fc, input int ff, input logic ps);
        chk({tag, "_a_captured"}, 32'(if_a.captured), 32'(cap));
        chk({tag, "_a_fail_count"}, 32'(if_a.fail_count), 32'(fc));
        chk({tag, "_a_first_fail"}, 32'(if_a.first_fail_idx), 32'(ff));
        chk({tag, "_a_pass"}, 32'(if_a.pass), 32'(ps));
        chk({tag, "_b_captured"}, 32'(if_b.captured), 32'(cap));
        chk({tag, "_b_fail_count"}, 32'(if_b.fail_count), 32'(fc));
        chk({tag, "_b_first_fail"}, 32'(if_b.first_fail_idx), 32'(ff));
        chk({tag, "_b_pass"}, 32'(if_b.pass), 32'(ps));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, cb;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(if_a.busy), 32'd0);
        chk("reset_done", 32'(if_a.done), 32'd0);
        chk("reset_pass", 32'(if_a.pass), 32'd0);
        chk("reset_stim", 32'(if_a.stim), 32'd0);
        chk("reset_captured", 32'(if_a.captured), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good block: all vectors match.
        run_sweep(-1, ca, cb);
        chk("good_cycles_a", 32'(ca), 32'd48);
        chk("good_cycles_b", 32'(cb), 32'd32);
        check_result("good", 16'hF888, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("done_hold_stim", 32'(if_a.stim), 32'd15);

        // Start from DONE, block wrong at vector 5 only.
        mode = 1;
        run_sweep(-1, ca, cb);
        chk("inv5_cycles_a", 32'(ca), 32'd48);
        check_result("inv5", 16'hF8A8, 1, 5, 1'b0);

        // Response stuck at 0.
        mode = 2;
        run_sweep(-1, ca, cb);
        chk("stuck0_cycles_a", 32'(ca), 32'd48);
        check_result("stuck0", 16'h0000, 7, 3, 1'b0);

        // Start re-pulsed during vector 4 must be ignored.
        mode = 0;
        run_sweep(12, ca, cb);
        chk("restart_cycles_a", 32'(ca), 32'd48);
        chk("restart_cycles_b", 32'(cb), 32'd32);
        check_result("restart", 16'hF888, 0, 0, 1'b1);

        // Reset landing on the SAMPLE edge of vector 9.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_reset_stim", 32'(if_a.stim), 32'd9);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 32'(if_a.busy), 32'd0);
        chk("midreset_done", 32'(if_a.done), 32'd0);
        chk("midreset_captured", 32'(if_a.captured), 32'd0);
        chk("midreset_stim", 32'(if_a.stim), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_sweep(-1, ca, cb);
        chk("post_reset_cycles_a", 32'(ca), 32'd48);
        check_result("post_reset", 16'hF888, 0, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Hardware counterpart to our exhaustive-stimulus benches: sweeps every N_IN-bit input vector into a combinational block under test and collects its 1-bit response.
- Packs the responses into a truth-table signature, compares it bit-by-bit against a golden table and reports pass/fail, mismatch count and first failing index.
- Sits beside a combinational function block (e.g. a 4-input gate network) as a self-checking on-chip or in-simulation harness.

Parameters:
- N_IN, 4, number of DUT inputs; sweep length 2**N_IN vectors.
- EXPECTED, 16'h0000 (width 2**N_IN), golden truth table; bit i = required response for vector i.
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; accepted only in IDLE or DONE.
- stim  output  N_IN  vector driven to the DUT; MSB = first DUT input (a), LSB = last (d).
- resp  input  1  DUT response, combinational from stim.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep end until the next accepted start.
- pass  output  1  valid when done; 1 iff fail_count == 0.
- captured  output  2**N_IN  sampled responses; bit i = resp for vector i.
- fail_count  output  N_IN+1  number of mismatching vectors, 0..2**N_IN.
- first_fail_idx  output  N_IN  index of the lowest-indexed mismatch; 0 if none.

Behaviour:
- Reset (rst_n low at an edge): state IDLE. stim, captured, fail_count and first_fail_idx = 0. busy, done and pass = 0. Reset has priority over all other inputs, including mid-sweep; the sweep is abandoned with no partial results kept.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE + start:
  - Go to APPLY.
  - Set idx = 0 and stim = 0.
  - Clear captured, fail_count, first_fail_idx and the internal seen_fail flag.
  - busy = 1, done = 0, pass = 0.
- APPLY:
  - stim = idx, held constant.
  - Settle counter runs 0..SETTLE-1.
  - Go to SAMPLE after SETTLE cycles.
- SAMPLE (1 cycle): at its closing edge:
  - captured[idx] <= resp.
  - If resp != EXPECTED[idx], fail_count increments (saturating at 2**N_IN).
  - If it is the first mismatch (seen_fail = 0), first_fail_idx <= idx and seen_fail <= 1.
  - If idx = 2**N_IN-1: go to DONE, busy = 0, done = 1, pass = (final fail_count == 0). Otherwise idx += 1 and return to APPLY.
- Timing: with start sampled at edge E0, vector i is sampled at edge E0+(i+1)*(SETTLE+1). done rises immediately after edge E0+2**N_IN*(SETTLE+1), which is 48 cycles for the defaults.
- stim changes only on the edge that enters APPLY, so the DUT sees exactly SETTLE+1 stable cycles before sampling.
- start while busy: ignored; no restart and no effect on results.
- start in DONE: starts a new sweep; the previous results are cleared on that edge.
- DONE with no start: all outputs hold indefinitely, and stim holds the last vector.
- idx is N_IN bits wide; it never wraps, because the terminal compare happens first.

Decomposition:
- Package tt_check_pkg holds:
  - state enum tt_state_e {IDLE, APPLY, SAMPLE, DONE};
  - default N_IN and SETTLE constants;
  - function vec_count(n) = 2**n.
- No sub-module is needed. The settle counter and index counter are small and stay inline, in one module of about 150 lines.

Test Plan:
- DUT model y = (a&b)|(c&d), EXPECTED = 16'hF888, start pulse -> done after 48 cycles, captured = 16'hF888, fail_count = 0, pass = 1, first_fail_idx = 0.
- Same DUT with the model output inverted only at stim = 5 -> captured = 16'hF8A8, fail_count = 1, first_fail_idx = 5, pass = 0.
- resp stuck at 0, EXPECTED = 16'hF888 -> captured = 16'h0000, fail_count = 7, first_fail_idx = 3, pass = 0.
- rst_n pulsed low at the SAMPLE of vector 9 -> next cycle: IDLE, busy = 0, done = 0, captured = 0, stim = 0; a new start then completes with the correct result.
- start re-pulsed at vector 4 while busy -> ignored; done still at cycle 48 with the correct result. start in DONE -> done falls next cycle, results cleared, sweep repeats.
- SETTLE = 1 -> vector i sampled at E0+2*(i+1), done after 32 cycles; check that stim is stable for 2 cycles per vector.
